// File: rtl/lsq_data_mem_responder_pkg.sv
// Shared types and helpers for the LSQ data-memory responder and its RAM.
// Used by both default builds and builds with DMEM_STATS_EN defined.
package lsq_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/lsq_data_mem_responder_if.sv
// LSQ memory issue port: the LSQ side is the master, the responder is the slave.
interface lsq_data_mem_responder_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] mem_read_val;
    logic        mem_err;
    logic        mem_busy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_data,
        input  mem_ack, mem_read_val, mem_err, mem_busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_data,
        output mem_ack, mem_read_val, mem_err, mem_busy
    );

endinterface

// File: rtl/lsq_data_mem_responder_dmem_array.sv
// Word-addressed data RAM: synchronous write, registered read (read-before-write).
module dmem_array
    import lsq_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [idx_width(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                       wdata,
    output logic [31:0]                       rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        r_rdata <= r_mem[idx];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/lsq_data_mem_responder.sv
// Single-outstanding memory responder for the LSQ with a fixed access latency.
// Optional DMEM_STATS_EN adds saturating rd_count/wr_count outputs.
module lsq_data_mem_responder
    import lsq_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lsq_data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
`endif
);

    localparam int         IW       = idx_width(DEPTH_WORDS);
    localparam int         OFS      = $clog2(WORD_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_cnt;
    logic [3:0]             w_next_cnt;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [31:0]            r_data;
    logic                   r_err;
    logic                   r_ld_hit;
    logic [31:0]            r_read_hold;
    logic [DEPTH_WORDS-1:0] r_written;

    logic [IW-1:0]          w_idx;
    logic                   w_misaligned;
    logic                   w_access;
    logic                   w_ram_we;
    logic [31:0]            w_rdata;
    logic [31:0]            w_read_val;
    logic                   w_unused;

    // Every access is served from the latched copy, so the bus fields are free after accept.
    assign w_idx        = r_addr[IW+OFS-1:OFS];
    assign w_misaligned = |r_addr[OFS-1:0];
    assign w_access     = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_ram_we     = w_access && r_we && !w_misaligned;
    assign w_unused     = ^r_addr[31:IW+OFS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Always passing through BUSY puts the ack LATENCY edges after accept, even for LATENCY=1.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    w_next_state = BUSY;
                    w_next_cnt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ACK;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= 32'h0;
            r_data <= 32'h0;
        end else if ((r_state == IDLE) && bus.mem_req) begin
            r_we   <= bus.mem_we;
            r_addr <= bus.mem_addr;
            r_data <= bus.mem_data;
        end
    end

    // r_written stands in for a zeroed RAM: words never stored since reset read back as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_ld_hit  <= 1'b0;
            r_written <= '0;
        end else if (w_access) begin
            r_err    <= w_misaligned;
            r_ld_hit <= !r_we && !w_misaligned && r_written[w_idx];
            if (w_ram_we) begin
                r_written[w_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_hold <= 32'h0;
        end else if (r_state == ACK) begin
            r_read_hold <= w_read_val;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk   (clk),
        .we    (w_ram_we),
        .idx   (w_idx),
        .wdata (r_data),
        .rdata (w_rdata)
    );

    assign w_read_val       = r_ld_hit ? w_rdata : 32'h0;
    assign bus.mem_ack      = (r_state == ACK);
    assign bus.mem_err      = (r_state == ACK) && r_err;
    assign bus.mem_read_val = (r_state == ACK) ? w_read_val : r_read_hold;
    assign bus.mem_busy     = (r_state != IDLE);

`ifdef DMEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 16'h0;
            r_wr_count <= 16'h0;
        end else if (w_access && !w_misaligned) begin
            if (r_we) begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_lsq_data_mem_responder.sv
// Scoreboard bench for lsq_data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
// Build with DMEM_STATS_EN defined to also check rd_count/wr_count.
module tb_lsq_data_mem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic [31:0] val;
        logic        err;
        int          lat;
    } expT;

    logic clk;
    logic rst_n;

    lsq_data_mem_responder_if bus0 ();
    lsq_data_mem_responder_if bus1 ();

`ifdef DMEM_STATS_EN
    logic [15:0] rdCountDut0, wrCountDut0, rdCountDut1, wrCountDut1;
`endif

    lsq_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rdCountDut0),
        .wr_count (wrCountDut0)
`endif
    );

    lsq_data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rdCountDut1),
        .wr_count (wrCountDut1)
`endif
    );

    int          totalCount = 0;
    int          badCount   = 0;
    expT         expQ[$];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    int          rdModel0, wrModel0, rdModel1, wrModel1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        rdModel0 = 0; wrModel0 = 0; rdModel1 = 0; wrModel1 = 0;
    endtask

    task automatic driveBus(input bit sel, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            bus1.mem_req = req; bus1.mem_we = we; bus1.mem_addr = addr; bus1.mem_data = data;
        end else begin
            bus0.mem_req = req; bus0.mem_we = we; bus0.mem_addr = addr; bus0.mem_data = data;
        end
    endtask

    // One full request/ack transaction; the expectation is queued before the request is driven.
    task automatic applyStimulus(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] data);
        expT        e;
        int         cycles;
        logic       ackNow;
        logic [7:0] idx;
        idx   = addr[9:2];
        e.lat = sel ? LAT1 : LAT0;
        e.err = (addr[1:0] != 2'b00);
        e.val = 32'h0;
        if (!e.err) begin
            if (we) begin
                if (sel) begin mem1[idx] = data; wrModel1++; end
                else     begin mem0[idx] = data; wrModel0++; end
            end else begin
                if (sel) begin e.val = mem1[idx]; rdModel1++; end
                else     begin e.val = mem0[idx]; rdModel0++; end
            end
        end
        expQ.push_back(e);

        @(negedge clk);
        driveBus(sel, 1'b1, we, addr, data);
        cycles = 0;
        ackNow = 1'b0;
        while (!ackNow && cycles < 40) begin
            @(negedge clk);
            cycles++;
            ackNow = sel ? bus1.mem_ack : bus0.mem_ack;
            if (cycles == 1)
                checkOutput("busyAfterAccept", 32'(sel ? bus1.mem_busy : bus0.mem_busy), 32'd1);
        end
        e = expQ.pop_front();
        if (!ackNow) begin
            checkOutput("ackTimeout", 32'd0, 32'd1);
        end else begin
            checkOutput("ackLatency", 32'(cycles - 1), 32'(e.lat));
            checkOutput("readVal", sel ? bus1.mem_read_val : bus0.mem_read_val, e.val);
            checkOutput("errFlag", 32'(sel ? bus1.mem_err : bus0.mem_err), 32'(e.err));
        end
        driveBus(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("ackSingle", 32'(sel ? bus1.mem_ack : bus0.mem_ack), 32'd0);
        checkOutput("busyFalls", 32'(sel ? bus1.mem_busy : bus0.mem_busy), 32'd0);
        checkOutput("readHold", sel ? bus1.mem_read_val : bus0.mem_read_val, e.val);
    endtask

    initial begin
        int ackCount;
        int firstAck;
        int secondAck;

        rst_n = 1'b0;
        driveBus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        driveBus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rstAck0", 32'(bus0.mem_ack), 32'd0);
        checkOutput("rstBusy0", 32'(bus0.mem_busy), 32'd0);
        checkOutput("rstErr0", 32'(bus0.mem_err), 32'd0);
        checkOutput("rstReadVal0", bus0.mem_read_val, 32'h0);
        checkOutput("rstAck1", 32'(bus1.mem_ack), 32'd0);
        checkOutput("rstBusy1", 32'(bus1.mem_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b1, 32'h10,  32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'h10,  32'h0);
        applyStimulus(1'b0, 1'b0, 32'h04,  32'h0);
        applyStimulus(1'b0, 1'b1, 32'h13,  32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h10,  32'h0);
        applyStimulus(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
        applyStimulus(1'b0, 1'b0, 32'h000, 32'h0);

        // mem_req held high across acks: each accept gets exactly one ack.
        @(negedge clk);
        driveBus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        ackCount  = 0;
        firstAck  = -1;
        secondAck = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus0.mem_ack) begin
                ackCount++;
                if (firstAck < 0) firstAck = i;
                else if (secondAck < 0) secondAck = i;
                checkOutput("heldReadVal", bus0.mem_read_val, mem0[4]);
            end
        end
        driveBus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rdModel0 += ackCount;
        checkOutput("heldAckCount", 32'(ackCount), 32'd3);
        checkOutput("heldAckGap", 32'(secondAck - firstAck), 32'(LAT0 + 2));
        @(negedge clk);
        checkOutput("heldBusyFalls", 32'(bus0.mem_busy), 32'd0);

        applyStimulus(1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h9, 32'h11111111);

        // Reset in the middle of a store: no ack, RAM left as zero.
        @(negedge clk);
        driveBus(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        checkOutput("busyBeforeAbort", 32'(bus0.mem_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(bus0.mem_busy), 32'd0);
        checkOutput("abortAck", 32'(bus0.mem_ack), 32'd0);
        checkOutput("abortReadVal", bus0.mem_read_val, 32'h0);
        driveBus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("noAckAfterAbort", 32'(bus0.mem_ack), 32'd0);

        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h01020304);
        applyStimulus(1'b0, 1'b1, 32'h34, 32'h0A0B0C0D);
        applyStimulus(1'b0, 1'b1, 32'h38, 32'hFFFF0000);
        applyStimulus(1'b0, 1'b0, 32'h34, 32'h0);

`ifdef DMEM_STATS_EN
        checkOutput("rdCount0", 32'(rdCountDut0), 32'(rdModel0));
        checkOutput("wrCount0", 32'(wrCountDut0), 32'(wrModel0));
        checkOutput("rdCount1", 32'(rdCountDut1), 32'(rdModel1));
        checkOutput("wrCount1", 32'(wrCountDut1), 32'(wrModel1));
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
